// File: rtl/if_fetch_queue_if.sv
// Loader/decode-facing signal bundle of the instruction-fetch stage.
// slave = fetch unit, master = loader/decode side driving redirects and ready.
interface if_fetch_queue_if #(
  parameter int INST_SZ = 32,
  parameter int PC_SZ   = 32,
  parameter int MEM_SZ  = 10
);
  logic               i_enable;
  logic               i_write;
  logic [INST_SZ-1:0] i_instruction_F;
  logic [PC_SZ-1:0]   i_branch_addr_D;
  logic [PC_SZ-1:0]   i_jump_addr_D;
  logic [PC_SZ-1:0]   i_rs_addr_D;
  logic               i_pc_src_D;
  logic               i_jump_D;
  logic               i_jump_sel_D;
  logic               i_halt;
  logic               i_ready_D;
  logic               o_valid_F;
  logic [INST_SZ-1:0] o_instruction_F;
  logic [PC_SZ-1:0]   o_pc;
  logic [PC_SZ-1:0]   o_npc_F;
  logic [PC_SZ-1:0]   o_branch_delay_slot_F;
  logic [PC_SZ-1:0]   o_fetch_pc;
  logic [MEM_SZ:0]    o_load_cnt;
  logic               o_halted;

  modport master (
    output i_enable, i_write, i_instruction_F, i_branch_addr_D, i_jump_addr_D,
           i_rs_addr_D, i_pc_src_D, i_jump_D, i_jump_sel_D, i_halt, i_ready_D,
    input  o_valid_F, o_instruction_F, o_pc, o_npc_F, o_branch_delay_slot_F,
           o_fetch_pc, o_load_cnt, o_halted
  );

  modport slave (
    input  i_enable, i_write, i_instruction_F, i_branch_addr_D, i_jump_addr_D,
           i_rs_addr_D, i_pc_src_D, i_jump_D, i_jump_sel_D, i_halt, i_ready_D,
    output o_valid_F, o_instruction_F, o_pc, o_npc_F, o_branch_delay_slot_F,
           o_fetch_pc, o_load_cnt, o_halted
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Fetch stage: loader-filled program memory feeding an FQ_DEPTH-entry prefetch queue.
// Issued read lands in the queue at the next edge; decode back-pressure via o_valid_F/i_ready_D.
module if_fetch_queue #(
  parameter int INST_SZ  = 32,
  parameter int PC_SZ    = 32,
  parameter int MEM_SZ   = 10,
  parameter int FQ_DEPTH = 4
) (
  input logic             i_clk,
  input logic             i_reset,
  if_fetch_queue_if.slave bus
);
  localparam int DEPTH_W   = $clog2(FQ_DEPTH);
  localparam int CNT_W     = DEPTH_W + 1;
  localparam int MEM_WORDS = 1 << MEM_SZ;
  localparam logic [MEM_SZ:0] LOAD_MAX = {1'b1, {MEM_SZ{1'b0}}};

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_HALT} state_t;

  state_t              state_q, state_d;
  logic [PC_SZ-1:0]    fetch_pc_q, fetch_pc_d;
  logic [MEM_SZ-1:0]   load_ptr_q, load_ptr_d;
  logic [MEM_SZ:0]     load_cnt_q, load_cnt_d;
  logic [DEPTH_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic [INST_SZ-1:0]  mem    [MEM_WORDS];
  logic [INST_SZ-1:0]  q_inst [FQ_DEPTH];
  logic [PC_SZ-1:0]    q_pc   [FQ_DEPTH];

  logic               run_en, redirect, issue, pop, head_vld, mem_we;
  logic [PC_SZ-1:0]   sel_addr, target, head_pc;
  logic [MEM_SZ-1:0]  fetch_idx;

  assign run_en    = (state_q == S_RUN) && bus.i_enable;
  assign redirect  = run_en && (bus.i_jump_sel_D || bus.i_jump_D || bus.i_pc_src_D);
  assign sel_addr  = bus.i_jump_sel_D ? bus.i_rs_addr_D :
                     bus.i_jump_D     ? bus.i_jump_addr_D : bus.i_branch_addr_D;
  assign target    = sel_addr & ~PC_SZ'(3);
  assign head_vld  = (count_q != '0) && (run_en || (state_q == S_HALT));
  assign pop       = head_vld && bus.i_ready_D;
  // The queue slot itself is the read register, so occupancy alone bounds issue.
  assign issue     = run_en && !bus.i_halt && !redirect && (count_q < CNT_W'(FQ_DEPTH));
  assign mem_we    = (state_q == S_LOAD) && bus.i_write;
  assign fetch_idx = fetch_pc_q[MEM_SZ+1:2];
  assign head_pc   = q_pc[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    load_ptr_d = load_ptr_q;
    load_cnt_d = load_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    case (state_q)
      S_LOAD: begin
        if (mem_we) begin
          load_ptr_d = load_ptr_q + 1'b1;
          if (load_cnt_q != LOAD_MAX) load_cnt_d = load_cnt_q + 1'b1;
        end
        if (bus.i_enable) state_d = S_RUN;
      end
      S_RUN:   if (bus.i_halt) state_d = S_HALT;
      default: state_d = state_q;
    endcase
    if (redirect) begin
      fetch_pc_d = target;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        wr_ptr_d   = wr_ptr_q + 1'b1;
        fetch_pc_d = fetch_pc_q + PC_SZ'(4);
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(issue) - CNT_W'(pop);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_LOAD;
      fetch_pc_q <= '0;
      load_ptr_q <= '0;
      load_cnt_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      load_ptr_q <= load_ptr_d;
      load_cnt_q <= load_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) mem[load_ptr_q] <= bus.i_instruction_F;
    if (issue) begin
      q_inst[wr_ptr_q] <= mem[fetch_idx];
      q_pc[wr_ptr_q]   <= fetch_pc_q;
    end
  end

  // Head fields read as zero whenever no entry is presented (reset, flush, pause).
  assign bus.o_valid_F             = head_vld;
  assign bus.o_instruction_F       = head_vld ? q_inst[rd_ptr_q] : '0;
  assign bus.o_pc                  = head_vld ? head_pc : '0;
  assign bus.o_npc_F               = head_vld ? head_pc + PC_SZ'(4) : '0;
  assign bus.o_branch_delay_slot_F = head_vld ? head_pc + PC_SZ'(8) : '0;
  assign bus.o_fetch_pc            = fetch_pc_q;
  assign bus.o_load_cnt            = load_cnt_q;
  assign bus.o_halted              = (state_q == S_HALT);
endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: queue-based reference model checked every negedge plus directed literal checks.
module tb_if_fetch_queue;
  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  if_fetch_queue_if #(.INST_SZ(32), .PC_SZ(32), .MEM_SZ(10)) bus ();

  if_fetch_queue #(.INST_SZ(32), .PC_SZ(32), .MEM_SZ(10), .FQ_DEPTH(4)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state as small integers, fetch queue as a queue of PCs.
  int          m_state = 0;  // 0 load, 1 run, 2 halt
  logic [31:0] m_fpc   = '0;
  int          m_lptr  = 0;
  int          m_lcnt  = 0;
  logic [31:0] m_q[$];
  logic [31:0] m_mem  [1024];
  bit          m_known[1024];

  always @(negedge clk) begin
    int          occ;
    bit          run, vld;
    logic [31:0] tgt;
    int          idx;
    if (rst) begin
      m_state = 0; m_fpc = '0; m_lptr = 0; m_lcnt = 0; m_q.delete();
    end
    run = (m_state == 1) && bus.i_enable;
    vld = (m_q.size() > 0) && (run || m_state == 2);
    chk("valid", bus.o_valid_F, vld);
    chk("halted", bus.o_halted, m_state == 2);
    chk("fetch_pc", bus.o_fetch_pc, m_fpc);
    chk("load_cnt", bus.o_load_cnt, m_lcnt);
    if (vld) begin
      chk("head_pc", bus.o_pc, m_q[0]);
      chk("npc", bus.o_npc_F, m_q[0] + 32'd4);
      chk("bds", bus.o_branch_delay_slot_F, m_q[0] + 32'd8);
      idx = int'((m_q[0] >> 2) & 32'h3ff);
      if (m_known[idx]) chk("head_inst", bus.o_instruction_F, m_mem[idx]);
    end
    if (!rst) begin
      if (m_state == 0) begin
        if (bus.i_write) begin
          m_mem[m_lptr] = bus.i_instruction_F;
          m_known[m_lptr] = 1'b1;
          m_lptr = (m_lptr + 1) % 1024;
          if (m_lcnt < 1024) m_lcnt++;
        end
        if (bus.i_enable) m_state = 1;
      end else begin
        occ = m_q.size();
        if (vld && bus.i_ready_D) void'(m_q.pop_front());
        if (run && (bus.i_jump_sel_D || bus.i_jump_D || bus.i_pc_src_D)) begin
          tgt = bus.i_jump_sel_D ? bus.i_rs_addr_D :
                bus.i_jump_D     ? bus.i_jump_addr_D : bus.i_branch_addr_D;
          m_fpc = {tgt[31:2], 2'b00};
          m_q.delete();
        end else if (run && !bus.i_halt && occ < 4) begin
          m_q.push_back(m_fpc);
          m_fpc = m_fpc + 32'd4;
        end
        if (m_state == 1 && bus.i_halt) m_state = 2;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic redirect(input bit js, input bit j, input bit ps,
                          input logic [31:0] rs, input logic [31:0] ja, input logic [31:0] ba);
    bus.i_jump_sel_D = js; bus.i_jump_D = j; bus.i_pc_src_D = ps;
    bus.i_rs_addr_D = rs; bus.i_jump_addr_D = ja; bus.i_branch_addr_D = ba;
    tick();
    bus.i_jump_sel_D = 1'b0; bus.i_jump_D = 1'b0; bus.i_pc_src_D = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.i_enable = 0; bus.i_write = 0; bus.i_instruction_F = '0;
    bus.i_branch_addr_D = '0; bus.i_jump_addr_D = '0; bus.i_rs_addr_D = '0;
    bus.i_pc_src_D = 0; bus.i_jump_D = 0; bus.i_jump_sel_D = 0;
    bus.i_halt = 0; bus.i_ready_D = 0;
    #3;
    chk("rst_valid", bus.o_valid_F, 0);
    chk("rst_fetch_pc", bus.o_fetch_pc, 0);
    chk("rst_load_cnt", bus.o_load_cnt, 0);
    chk("rst_halted", bus.o_halted, 0);
    ticks(2);
    rst = 1'b0;

    // Load 64 words 0x1000_0000+k.
    for (int k = 0; k < 64; k++) begin
      bus.i_write = 1'b1;
      bus.i_instruction_F = 32'h1000_0000 + k;
      tick();
    end
    bus.i_write = 1'b0;
    chk("load_cnt_64", bus.o_load_cnt, 64);

    // Streaming with ready held high.
    bus.i_enable = 1'b1; bus.i_ready_D = 1'b1;
    tick();
    chk("first_run_cycle_valid", bus.o_valid_F, 0);
    tick();
    chk("stream_valid", bus.o_valid_F, 1);
    chk("stream_npc0", bus.o_npc_F, 32'h4);
    chk("stream_bds0", bus.o_branch_delay_slot_F, 32'h8);
    for (int k = 0; k < 8; k++) begin
      chk("stream_pc", bus.o_pc, 4 * k);
      chk("stream_inst", bus.o_instruction_F, 32'h1000_0000 + k);
      tick();
    end

    // Fill the queue, then reset mid-stream.
    bus.i_ready_D = 1'b0;
    ticks(6);
    rst = 1'b1;
    #1;
    chk("midrst_valid", bus.o_valid_F, 0);
    chk("midrst_pc", bus.o_pc, 0);
    chk("midrst_inst", bus.o_instruction_F, 0);
    chk("midrst_npc", bus.o_npc_F, 0);
    chk("midrst_fetch_pc", bus.o_fetch_pc, 0);
    chk("midrst_load_cnt", bus.o_load_cnt, 0);
    tick();
    rst = 1'b0;

    // Restart with decode stalled: exactly four entries prefetched.
    ticks(11);
    chk("bp_fetch_pc", bus.o_fetch_pc, 32'h10);
    chk("bp_head_pc", bus.o_pc, 32'h0);
    chk("bp_head_inst", bus.o_instruction_F, 32'h1000_0000);
    bus.i_ready_D = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("release_valid", bus.o_valid_F, 1);
      chk("release_pc", bus.o_pc, 4 * i);
      tick();
    end

    // jump-register wins over jump and branch; low bits cleared.
    redirect(1, 1, 1, 32'h23, 32'h81, 32'h40);
    chk("jr_flush_valid", bus.o_valid_F, 0);
    tick();
    chk("jr_pc", bus.o_pc, 32'h20);
    chk("jr_inst", bus.o_instruction_F, 32'h1000_0008);

    redirect(1, 0, 0, 32'h0A, 32'h0, 32'h0);
    tick();
    chk("to8_pc", bus.o_pc, 32'h8);

    // Jump wins over branch while head is 0x8.
    redirect(0, 1, 1, 32'h0, 32'h81, 32'h40);
    chk("j_flush_valid", bus.o_valid_F, 0);
    tick();
    chk("j_pc", bus.o_pc, 32'h80);
    chk("j_inst", bus.o_instruction_F, 32'h1000_0020);

    redirect(0, 0, 1, 32'h0, 32'h0, 32'h40);
    chk("br_flush_valid", bus.o_valid_F, 0);
    tick();
    chk("br_pc", bus.o_pc, 32'h40);

    // Halt with two entries queued.
    bus.i_ready_D = 1'b0;
    redirect(0, 0, 1, 32'h0, 32'h0, 32'h60);
    ticks(2);
    bus.i_halt = 1'b1;
    tick();
    bus.i_halt = 1'b0;
    chk("halt_flag", bus.o_halted, 1);
    chk("halt_fetch_pc", bus.o_fetch_pc, 32'h68);
    chk("halt_head_pc", bus.o_pc, 32'h60);
    redirect(1, 0, 0, 32'h200, 32'h0, 32'h0);
    chk("halt_redirect_ignored", bus.o_fetch_pc, 32'h68);
    chk("halt_head_kept", bus.o_pc, 32'h60);
    bus.i_ready_D = 1'b1;
    tick();
    chk("halt_drain_pc", bus.o_pc, 32'h64);
    tick();
    chk("halt_drained", bus.o_valid_F, 0);
    ticks(2);
    chk("halt_sticky", bus.o_halted, 1);

    // Reset, overfill memory: counter saturates, pointer wraps.
    rst = 1'b1;
    tick();
    rst = 1'b0; bus.i_enable = 1'b0;
    chk("halt_cleared", bus.o_halted, 0);
    for (int k = 0; k < 1030; k++) begin
      bus.i_write = 1'b1;
      bus.i_instruction_F = 32'hA000_0000 + k;
      tick();
    end
    bus.i_write = 1'b0;
    chk("load_cnt_sat", bus.o_load_cnt, 11'h400);
    bus.i_enable = 1'b1;
    ticks(2);
    chk("wrap_pc0", bus.o_pc, 32'h0);
    chk("wrap_inst0", bus.o_instruction_F, 32'hA000_0400);
    tick();
    bus.i_enable = 1'b0;
    #1;
    chk("pause_valid", bus.o_valid_F, 0);
    ticks(2);
    bus.i_enable = 1'b1;
    #1;
    chk("resume_pc", bus.o_pc, 32'h4);
    ticks(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
